tc_stream_ram: RTL and testbench
================================

// Module: tc_stream_ram
// PURPOSE
// - Parametrised multi-read-port RAM/ROM; successor to the file-loaded single-port ROM component.
// - Contents arrive over a byte-stream load channel (valid/ready), not simulator file I/O, so the block synthesises.
// - Optional zero sweep on reset; N independent synchronous read ports and one write port.
// - Sits as program/data memory in translated circuits; the testbench or boot logic drives the load channel.
// PARAMETERS
// - BIT_WIDTH      16   word width; multiple of 8, 8..64
// - BIT_DEPTH      256  words; 2..65536
// - READ_PORTS     2    independent read ports, 1..4
// - CLEAR_ON_RESET 1    1: zero all words after reset before load; 0: skip the sweep
// PORTS
// - clk        in   1                  single clock; all state updates on posedge
// - rst        in   1                  synchronous, active-low reset
// - ld_valid   in   1                  load byte valid
// - ld_ready   out  1                  block accepts the byte this cycle
// - ld_data    in   8                  load byte; little-endian within each word
// - ld_last    in   1                  final byte of the image; qualified by ld_valid
// - busy       out  1                  clear or load in progress; memory ports inactive
// - ld_ovf     out  1                  sticky: the image was larger than BIT_DEPTH words
// - load       in   READ_PORTS         per-port read enable
// - address    in   16*READ_PORTS      per-port word address; port k = [16k+15:16k]
// - out        out  BIT_WIDTH*READ_PORTS  per-port read data
// - save       in   1                  write enable
// - save_addr  in   16                 write address
// - in         in   BIT_WIDTH          write data
// BEHAVIOUR
// - Reset (rst==0 at posedge): all outputs 0, ld_ready=0, busy=1; byte/word counters cleared; ld_ovf cleared.
//   Any clear or load in progress aborts. Memory contents are untouched except by the sweep.
// - FSM states: CLEAR -> LOAD -> RUN.
//   - Reset enters CLEAR if CLEAR_ON_RESET=1, otherwise LOAD.
//   - CLEAR writes 0 to one word per cycle at addresses 0..BIT_DEPTH-1; after the last word it moves to LOAD.
//     The sweep takes exactly BIT_DEPTH cycles.
//   - LOAD: ld_ready=1. Each ld_valid&ld_ready cycle consumes one byte into byte lane b, with b wrapping at BIT_WIDTH/8.
//     - A word is written when its last lane fills, or on ld_last; unfilled upper lanes are written as 0.
//     - The word address increments per written word.
//     - Words beyond BIT_DEPTH-1 are dropped and set ld_ovf=1; ld_ovf stays set until reset.
//     - The ld_last byte is accepted and the FSM enters RUN on the following cycle; ld_ready drops with it.
//   - RUN: busy=0, ld_ready=0. ld_valid is ignored until the next reset.
// - Read path:
//   - Latency 1: out[k] at cycle t+1 = mem[address[k]] sampled at t, when load[k]=1 and busy=0 at t.
//   - Otherwise out[k]=0 at t+1, including any cycle where busy=1.
//   - address >= BIT_DEPTH reads 0.
// - Write path: in RUN, save=1 at posedge writes in to mem[save_addr]. Ignored while busy or when save_addr >= BIT_DEPTH.
// - Read/write collision (same address, same cycle): the read returns the OLD word. The new word is visible from the next read.
// - Several ports reading the same address all receive identical data.
// - An empty image (ld_last on the first byte with BIT_WIDTH>8) writes word 0 as {0..., byte}.
// STRUCTURE
// - Package tc_stream_ram_pkg:
//   - state enum {ST_CLEAR, ST_LOAD, ST_RUN}
//   - ADDR_W=16
//   - function lanes(BIT_WIDTH) = BIT_WIDTH/8
// - Sub-module tc_stream_ram_loader: the FSM, byte-lane assembler, clear/load address counter and ld_ovf.
//   It emits one internal write request (wen, waddr, wdata).
// - Top level: memory array, write mux (loader request while busy, else the save port), per-port registered read.
// TESTING
// - Clear sweep: BIT_DEPTH=8, CLEAR_ON_RESET=1, rst low 1 cycle.
//   Expect busy=1 for 8 cycles, then ld_ready=1. All words read 0x0000 after load.
// - Byte load: BIT_WIDTH=16, stream 01,02,03,04,05 with ld_last on 05.
//   Expect mem[0]=0x0201, mem[1]=0x0403, mem[2]=0x0005; busy drops the cycle after ld_last.
// - Overflow: BIT_DEPTH=4, stream 10 bytes (5 words) with BIT_WIDTH=16.
//   Expect ld_ovf=1; mem[0..3] hold words 0..3; no write to address 0 from the 5th word.
// - Multi-port and collision:
//   - RUN, READ_PORTS=2, mem[3]=0xAAAA. save=1, save_addr=3, in=0x5555, with load[0]=1, address[0]=3 in the same cycle.
//   - Expect out[0]=0xAAAA next cycle; 0x5555 on the following read.
//   - Port 1 address 0x0100 (>= BIT_DEPTH) reads 0.
// - Reset mid-load: assert rst after 3 bytes.
//   Expect ld_ready=0, busy=1, counters restart. Word 0 rewritten by the new stream; ld_ovf=0.
// - Gated reads: load[k]=0, or any cycle with busy=1 -> out[k]=0 next cycle, regardless of address.

Source files
------------

// File: rtl/tc_stream_ram_pkg.sv
// Shared types and helpers for the streamed-load multi-port RAM.
package tc_stream_ram_pkg;

    localparam int unsigned ADDR_W = 16;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_LOAD,
        ST_RUN
    } state_t;

    function automatic int unsigned lanes(input int unsigned bit_width);
        return bit_width / 8;
    endfunction

endpackage

// File: rtl/tc_stream_ram_loader.sv
// Boot sequencer: optional zero sweep, then byte-stream image load into words.
module tc_stream_ram_loader
    import tc_stream_ram_pkg::*;
#(
    parameter int unsigned BIT_WIDTH      = 16,
    parameter int unsigned BIT_DEPTH      = 256,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ld_valid,
    input  logic [7:0]           ld_data,
    input  logic                 ld_last,
    output logic                 ld_ready,
    output logic                 busy,
    output logic                 ld_ovf,
    output logic                 wen_c,
    output logic [ADDR_W-1:0]    waddr_c,
    output logic [BIT_WIDTH-1:0] wdata_c
);

    localparam int unsigned LANES  = lanes(BIT_WIDTH);
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned CNT_W  = ADDR_W + 1;

    state_t               state;
    state_t               state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [LANE_W-1:0]    lane;
    logic [BIT_WIDTH-1:0] acc;
    logic [BIT_WIDTH-1:0] acc_nxt;
    logic                 accept_c;
    logic                 word_done_c;
    logic                 in_range_c;

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (CLEAR_ON_RESET != 0) state <= ST_CLEAR;
            else                     state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus the single write request shared by sweep and load.
    always_comb begin
        state_nxt   = state;
        accept_c    = 1'b0;
        word_done_c = 1'b0;
        acc_nxt     = acc;
        wen_c       = 1'b0;
        waddr_c     = '0;
        wdata_c     = '0;
        in_range_c  = (32'(cnt) < BIT_DEPTH);
        case (state)
            ST_CLEAR: begin
                wen_c   = 1'b1;
                waddr_c = ADDR_W'(cnt);
                if (32'(cnt) == BIT_DEPTH - 1) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                accept_c = ld_valid && ld_ready;
                if (accept_c) begin
                    acc_nxt     = acc | (BIT_WIDTH'(ld_data) << {lane, 3'b000});
                    word_done_c = (32'(lane) == LANES - 1) || ld_last;
                    wen_c       = word_done_c && in_range_c;
                    waddr_c     = ADDR_W'(cnt);
                    wdata_c     = acc_nxt;
                    if (ld_last) state_nxt = ST_RUN;
                end
            end
            ST_RUN: ;
            default: state_nxt = ST_RUN;
        endcase
    end

    // Counters, lane assembler and handshake/status registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt      <= '0;
            lane     <= '0;
            acc      <= '0;
            ld_ovf   <= 1'b0;
            ld_ready <= 1'b0;
            busy     <= 1'b1;
        end else begin
            ld_ready <= (state_nxt == ST_LOAD);
            busy     <= (state_nxt != ST_RUN);
            if (state == ST_CLEAR) begin
                cnt <= (state_nxt == ST_LOAD) ? '0 : cnt + 1'b1;
            end else if (accept_c) begin
                if (word_done_c) begin
                    lane <= '0;
                    acc  <= '0;
                    // Counter parks at BIT_DEPTH; further words are dropped.
                    if (in_range_c) cnt <= cnt + 1'b1;
                    else            ld_ovf <= 1'b1;
                end else begin
                    lane <= lane + 1'b1;
                    acc  <= acc_nxt;
                end
            end
        end
    end

endmodule

// File: rtl/tc_stream_ram.sv
// Multi-read-port RAM whose initial image is streamed in byte by byte after reset.
module tc_stream_ram
    import tc_stream_ram_pkg::*;
#(
    parameter int unsigned BIT_WIDTH      = 16,
    parameter int unsigned BIT_DEPTH      = 256,
    parameter int unsigned READ_PORTS     = 2,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ld_valid,
    output logic                            ld_ready,
    input  logic [7:0]                      ld_data,
    input  logic                            ld_last,
    output logic                            busy,
    output logic                            ld_ovf,
    input  logic [READ_PORTS-1:0]           load,
    input  logic [ADDR_W*READ_PORTS-1:0]    address,
    output logic [BIT_WIDTH*READ_PORTS-1:0] out,
    input  logic                            save,
    input  logic [ADDR_W-1:0]               save_addr,
    input  logic [BIT_WIDTH-1:0]            in
);

    localparam int unsigned AW = (BIT_DEPTH > 1) ? $clog2(BIT_DEPTH) : 1;

    logic [BIT_WIDTH-1:0] mem [BIT_DEPTH];
    logic                 wen_c;
    logic [ADDR_W-1:0]    waddr_c;
    logic [BIT_WIDTH-1:0] wdata_c;

    tc_stream_ram_loader #(
        .BIT_WIDTH      (BIT_WIDTH),
        .BIT_DEPTH      (BIT_DEPTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_loader (
        .clk      (clk),
        .rst      (rst),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_last  (ld_last),
        .ld_ready (ld_ready),
        .busy     (busy),
        .ld_ovf   (ld_ovf),
        .wen_c    (wen_c),
        .waddr_c  (waddr_c),
        .wdata_c  (wdata_c)
    );

    // Loader owns the write port while busy; the save port takes it in RUN.
    always_ff @(posedge clk) begin
        if (wen_c && (32'(waddr_c) < BIT_DEPTH)) begin
            mem[waddr_c[AW-1:0]] <= wdata_c;
        end else if (!busy && save && (32'(save_addr) < BIT_DEPTH)) begin
            mem[save_addr[AW-1:0]] <= in;
        end
    end

    // Registered reads see pre-write contents on a same-cycle collision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out <= '0;
        end else begin
            for (int k = 0; k < int'(READ_PORTS); k++) begin
                if (load[k] && !busy && (32'(address[k*ADDR_W +: ADDR_W]) < BIT_DEPTH)) begin
                    out[k*BIT_WIDTH +: BIT_WIDTH] <= mem[address[k*ADDR_W +: AW]];
                end else begin
                    out[k*BIT_WIDTH +: BIT_WIDTH] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_tc_stream_ram.sv
// Directed bench for tc_stream_ram: sweep, streamed load, overflow, reset abort and read/write ports.
module tb_tc_stream_ram;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: 16-bit words, depth 8, zero sweep enabled.
    logic        rst, ld_valid, ld_last, save;
    logic [7:0]  ld_data;
    logic [1:0]  rd_en;
    logic [31:0] rd_addr;
    logic [15:0] save_addr, wr_data;
    logic [31:0] rd_data;
    logic        ld_ready, busy, ld_ovf;

    // Overflow instance: 16-bit words, depth 4, no sweep.
    logic        b_rst, b_ld_valid, b_ld_last;
    logic [7:0]  b_ld_data;
    logic [1:0]  b_rd_en;
    logic [31:0] b_rd_addr;
    logic [31:0] b_rd_data;
    logic        b_ld_ready, b_busy, b_ld_ovf;
    logic        b_save;
    logic [15:0] b_save_addr, b_wr_data;

    tc_stream_ram #(.BIT_WIDTH(16), .BIT_DEPTH(8), .READ_PORTS(2), .CLEAR_ON_RESET(1)) dut (
        .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .ld_last(ld_last), .busy(busy), .ld_ovf(ld_ovf), .load(rd_en), .address(rd_addr),
        .out(rd_data), .save(save), .save_addr(save_addr), .in(wr_data)
    );

    tc_stream_ram #(.BIT_WIDTH(16), .BIT_DEPTH(4), .READ_PORTS(2), .CLEAR_ON_RESET(0)) dut4 (
        .clk(clk), .rst(b_rst), .ld_valid(b_ld_valid), .ld_ready(b_ld_ready), .ld_data(b_ld_data),
        .ld_last(b_ld_last), .busy(b_busy), .ld_ovf(b_ld_ovf), .load(b_rd_en), .address(b_rd_addr),
        .out(b_rd_data), .save(b_save), .save_addr(b_save_addr), .in(b_wr_data)
    );

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [1:0]  en;
        logic [15:0] a0;
        logic [15:0] a1;
        logic        sv;
        logic [15:0] sa;
        logic [15:0] wd;
        logic [15:0] e0;
        logic [15:0] e1;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep8();
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("sweep_busy", 32'(busy), 32'd1);
            chk("sweep_ld_ready", 32'(ld_ready), 32'(i == 8));
            chk("sweep_read_gated", rd_data, 32'h0);
        end
    endtask

    task automatic push8(input logic [7:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        chk("ld_ready_for_byte", 32'(ld_ready), 32'd1);
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        chk("load_read_gated", rd_data, 32'h0);
        chk("busy_after_byte", 32'(busy), 32'(!last));
        chk("ld_ready_after_byte", 32'(ld_ready), 32'(!last));
    endtask

    task automatic push4(input logic [7:0] d, input logic last);
        b_ld_valid = 1'b1;
        b_ld_data  = d;
        b_ld_last  = last;
        chk("b_ld_ready_for_byte", 32'(b_ld_ready), 32'd1);
        tick();
        b_ld_valid = 1'b0;
        b_ld_last  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, n_fail=%0d", n_fail);
        $fatal(1);
    end

    initial begin
        logic [15:0] exp_w;

        vecs[0]  = '{2'b11, 16'h0000, 16'h0001, 1'b0, 16'h0000, 16'h0000, 16'h0201, 16'h0403};
        vecs[1]  = '{2'b01, 16'h0002, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0005, 16'h0000};
        vecs[2]  = '{2'b10, 16'h0000, 16'h0002, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0005};
        vecs[3]  = '{2'b11, 16'h0003, 16'h0007, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[4]  = '{2'b00, 16'h0003, 16'h0003, 1'b1, 16'h0003, 16'hAAAA, 16'h0000, 16'h0000};
        vecs[5]  = '{2'b11, 16'h0003, 16'h0003, 1'b0, 16'h0000, 16'h0000, 16'hAAAA, 16'hAAAA};
        vecs[6]  = '{2'b11, 16'h0003, 16'h0100, 1'b1, 16'h0003, 16'h5555, 16'hAAAA, 16'h0000};
        vecs[7]  = '{2'b01, 16'h0003, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h5555, 16'h0000};
        vecs[8]  = '{2'b11, 16'h0000, 16'h0008, 1'b1, 16'h0008, 16'hFFFF, 16'h0201, 16'h0000};
        vecs[9]  = '{2'b11, 16'h0000, 16'h0003, 1'b0, 16'h0000, 16'h0000, 16'h0201, 16'h5555};
        vecs[10] = '{2'b11, 16'h0007, 16'hFFFF, 1'b1, 16'h0007, 16'h1234, 16'h0000, 16'h0000};
        vecs[11] = '{2'b11, 16'h0007, 16'h0007, 1'b0, 16'h0000, 16'h0000, 16'h1234, 16'h1234};
        vecs[12] = '{2'b11, 16'h0001, 16'h0002, 1'b1, 16'h0001, 16'hBEEF, 16'h0403, 16'h0005};
        vecs[13] = '{2'b11, 16'h0001, 16'h0001, 1'b0, 16'h0000, 16'h0000, 16'hBEEF, 16'hBEEF};

        rst = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = 8'h00; save = 1'b0;
        rd_en = 2'b11; rd_addr = 32'h0001_0000; save_addr = 16'h0; wr_data = 16'h0;
        b_rst = 1'b0; b_ld_valid = 1'b0; b_ld_last = 1'b0; b_ld_data = 8'h00;
        b_rd_en = 2'b00; b_rd_addr = 32'h0; b_save = 1'b0; b_save_addr = 16'h0; b_wr_data = 16'h0;

        // Reset state, then the zero sweep over 8 words.
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_ld_ready", 32'(ld_ready), 32'd0);
        chk("rst_ld_ovf", 32'(ld_ovf), 32'd0);
        chk("rst_out", rd_data, 32'h0);
        rst = 1'b1;
        sweep8();

        // Byte load 01..05 -> 0x0201, 0x0403, 0x0005.
        push8(8'h01, 1'b0);
        push8(8'h02, 1'b0);
        push8(8'h03, 1'b0);
        push8(8'h04, 1'b0);
        push8(8'h05, 1'b1);
        chk("load_ld_ovf", 32'(ld_ovf), 32'd0);

        // RUN-mode read/write vectors.
        for (int i = 0; i < 14; i++) begin
            rd_en     = vecs[i].en;
            rd_addr   = {vecs[i].a1, vecs[i].a0};
            save      = vecs[i].sv;
            save_addr = vecs[i].sa;
            wr_data   = vecs[i].wd;
            tick();
            chk($sformatf("vec%0d_out0", i), 32'(rd_data[15:0]), 32'(vecs[i].e0));
            chk($sformatf("vec%0d_out1", i), 32'(rd_data[31:16]), 32'(vecs[i].e1));
        end
        save = 1'b0;

        // Load channel is ignored in RUN.
        ld_valid = 1'b1; ld_data = 8'h77; ld_last = 1'b1;
        rd_en = 2'b01; rd_addr = 32'h0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("run_ld_ready", 32'(ld_ready), 32'd0);
            chk("run_busy", 32'(busy), 32'd0);
            chk("run_word0_kept", rd_data, 32'h0000_0201);
        end
        ld_valid = 1'b0; ld_last = 1'b0;

        // Reset mid-load aborts; counters and lane restart.
        rd_en = 2'b11; rd_addr = {16'h0003, 16'h0001};
        rst = 1'b0;
        tick();
        chk("rst2_busy", 32'(busy), 32'd1);
        chk("rst2_ld_ready", 32'(ld_ready), 32'd0);
        chk("rst2_out", rd_data, 32'h0);
        rst = 1'b1;
        sweep8();
        push8(8'h11, 1'b0);
        push8(8'h22, 1'b0);
        push8(8'h33, 1'b0);
        rst = 1'b0;
        tick();
        chk("abort_ld_ready", 32'(ld_ready), 32'd0);
        chk("abort_busy", 32'(busy), 32'd1);
        chk("abort_ld_ovf", 32'(ld_ovf), 32'd0);
        rst = 1'b1;
        sweep8();
        push8(8'h99, 1'b1);
        for (int a = 0; a < 8; a++) begin
            rd_en = 2'b11;
            rd_addr = {16'(7 - a), 16'(a)};
            tick();
            exp_w = (a == 0) ? 16'h0099 : 16'h0000;
            chk($sformatf("reload_word%0d", a), 32'(rd_data[15:0]), 32'(exp_w));
            exp_w = (a == 7) ? 16'h0099 : 16'h0000;
            chk($sformatf("reload_word%0d_p1", 7 - a), 32'(rd_data[31:16]), 32'(exp_w));
        end

        // Overflow on the depth-4 instance: 10 bytes, fifth word dropped.
        chk("b_rst_busy", 32'(b_busy), 32'd1);
        chk("b_rst_ld_ready", 32'(b_ld_ready), 32'd0);
        b_rst = 1'b1;
        tick();
        chk("b_ld_ready_up", 32'(b_ld_ready), 32'd1);
        for (int i = 0; i < 10; i++) begin
            push4(8'(8'h10 + i), (i == 9));
            if (i == 7) chk("b_ovf_not_yet", 32'(b_ld_ovf), 32'd0);
        end
        chk("b_ovf_set", 32'(b_ld_ovf), 32'd1);
        chk("b_busy_done", 32'(b_busy), 32'd0);
        for (int a = 0; a < 4; a++) begin
            b_rd_en = 2'b11;
            b_rd_addr = {16'(a + 4), 16'(a)};
            tick();
            exp_w = {8'(8'h11 + 2 * a), 8'(8'h10 + 2 * a)};
            chk($sformatf("b_word%0d", a), 32'(b_rd_data[15:0]), 32'(exp_w));
            chk($sformatf("b_oob%0d", a + 4), 32'(b_rd_data[31:16]), 32'h0);
        end
        chk("b_ovf_sticky", 32'(b_ld_ovf), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
